// File: rtl/i2c_write_master_if.sv
// i2c_write_master_if
//
// Bundles the request/status handshake and the I2C pad signals of
// i2c_write_master so the master and its requester share one port.
//
// Signals:
//   start    request pulse from the configuration sequencer
//   wdata    bytes to send, first byte in the top 8 bits, MSB first
//   len      number of bytes to send (1..NBYTES)
//   sda_in   synchronised SDA pad value
//   scl      SCL drive (push-pull)
//   sda_out  SDA drive value
//   sda_ts   1 = release SDA (high-Z)
//   busy     transaction in progress
//   done     one-cycle completion pulse
//   ack_err  NACK seen in the last transaction
//   retries  restarts used in the last transaction (only with I2C_RETRY_EN)
//
// Modports:
//   master  the I2C write master itself
//   slave   the requester / pad side that drives the request and sda_in
//
// Optional feature macro: I2C_RETRY_EN adds the MAX_RETRY parameter and the
// retries signal.
interface i2c_write_master_if #(
    parameter int NBYTES = 3
`ifdef I2C_RETRY_EN
    ,
    parameter int MAX_RETRY = 3
`endif
);
    localparam int LW = $clog2(NBYTES + 1);

    logic                  start;
    logic [8*NBYTES-1:0]   wdata;
    logic [LW-1:0]         len;
    logic                  sda_in;
    logic                  scl;
    logic                  sda_out;
    logic                  sda_ts;
    logic                  busy;
    logic                  done;
    logic                  ack_err;
`ifdef I2C_RETRY_EN
    logic [$clog2(MAX_RETRY+1)-1:0] retries;
`endif

    modport master (
        input  start,
        input  wdata,
        input  len,
        input  sda_in,
        output scl,
        output sda_out,
        output sda_ts,
        output busy,
        output done,
        output ack_err
`ifdef I2C_RETRY_EN
        ,
        output retries
`endif
    );

    modport slave (
        output start,
        output wdata,
        output len,
        output sda_in,
        input  scl,
        input  sda_out,
        input  sda_ts,
        input  busy,
        input  done,
        input  ack_err
`ifdef I2C_RETRY_EN
        ,
        input  retries
`endif
    );
endinterface

// File: rtl/i2c_write_master.sv
// i2c_write_master
//
// I2C write master for codec bring-up. Each accepted request produces one
// START / N-byte write / STOP transaction and checks the slave ACK after
// every byte. SCL is driven push-pull; SDA is an open-drain pair where the
// pad resolves as FPGA_I2C_SDAT = sda_ts ? Z : sda_out.
//
// Ports:
//   clk    system clock, all logic on the rising edge
//   reset  synchronous active-high reset
//   bus    i2c_write_master_if.master: start/wdata/len request, sda_in pad
//          input, scl/sda_out/sda_ts pad drive, busy/done/ack_err status
//          (plus retries with I2C_RETRY_EN)
//
// Parameters:
//   NBYTES     maximum bytes per transaction including the address byte
//   CLK_DIV    clk cycles per quarter SCL period (>= 2)
//   MAX_RETRY  restarts after a NACK (only with I2C_RETRY_EN)
//
// Optional feature macro: I2C_RETRY_EN. When defined, a NACKed transaction
// is restarted from byte 0 after STOP and four idle phases, up to MAX_RETRY
// times, and the retries count is reported on the interface.
module i2c_write_master #(
    parameter int NBYTES  = 3,
    parameter int CLK_DIV = 125
`ifdef I2C_RETRY_EN
    ,
    parameter int MAX_RETRY = 3
`endif
) (
    input  logic               clk,
    input  logic               reset,
    i2c_write_master_if.master bus
);
    localparam int LW = $clog2(NBYTES + 1);
    localparam int QW = $clog2(CLK_DIV);
    localparam int DW = 8 * NBYTES;
`ifdef I2C_RETRY_EN
    localparam int RW = $clog2(MAX_RETRY + 1);
`endif

    // Every non-idle state lasts exactly one quarter tick; the bit and ACK
    // slots are spelled out as four states each so the bus levels follow
    // directly from the state.
    typedef enum logic [4:0] {
        S_IDLE,
        S_START1,
        S_START2,
        S_BQ0,
        S_BQ1,
        S_BQ2,
        S_BQ3,
        S_AQ0,
        S_AQ1,
        S_AQ2,
        S_AQ3,
        S_STOP1,
        S_STOP2,
        S_STOP3,
        S_RWAIT,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [QW-1:0]   q_cnt_q, q_cnt_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [LW-1:0]   byte_cnt_q, byte_cnt_d;
    logic [LW-1:0]   len_q, len_d;
    logic [DW-1:0]   shreg_q, shreg_d;
    logic            nack_q, nack_d;
    logic            ack_err_q, ack_err_d;
    logic            scl_q, scl_d;
    logic            sda_out_q, sda_out_d;
    logic            sda_ts_q, sda_ts_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            tick;
    logic            accept;
    logic            last_attempt;
    logic            data_bit;
`ifdef I2C_RETRY_EN
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [RW-1:0]   retry_cnt_q, retry_cnt_d;
`endif

    assign accept = bus.start && (bus.len != '0) && (bus.len <= LW'(NBYTES));

    // A NACK only counts as a reportable error when no restart remains.
`ifdef I2C_RETRY_EN
    assign last_attempt = (retry_cnt_q == RW'(MAX_RETRY));
`else
    assign last_attempt = 1'b1;
`endif

    // State register plus the registered pad and status outputs. Outputs are
    // registered from the next-state decode so SCL/SDA never glitch.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            q_cnt_q    <= '0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            len_q      <= '0;
            shreg_q    <= '0;
            nack_q     <= 1'b0;
            ack_err_q  <= 1'b0;
            scl_q      <= 1'b1;
            sda_out_q  <= 1'b1;
            sda_ts_q   <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef I2C_RETRY_EN
            wdata_q    <= '0;
            retry_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            q_cnt_q    <= q_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            len_q      <= len_d;
            shreg_q    <= shreg_d;
            nack_q     <= nack_d;
            ack_err_q  <= ack_err_d;
            scl_q      <= scl_d;
            sda_out_q  <= sda_out_d;
            sda_ts_q   <= sda_ts_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef I2C_RETRY_EN
            wdata_q    <= wdata_d;
            retry_cnt_q <= retry_cnt_d;
`endif
        end
    end

    // Next-state logic. Phase changes happen on the last cycle of a quarter
    // tick; the ACK is sampled on the last cycle of its Q2 phase and acted on
    // at the end of Q3. The shift register moves one bit at the end of each
    // bit slot, so after eight shifts the next byte sits at the top.
    always_comb begin
        tick       = (q_cnt_q == QW'(CLK_DIV - 1));
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        len_d      = len_q;
        shreg_d    = shreg_q;
        nack_d     = nack_q;
        ack_err_d  = ack_err_q;
`ifdef I2C_RETRY_EN
        wdata_d     = wdata_q;
        retry_cnt_d = retry_cnt_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d    = S_START1;
                    len_d      = bus.len;
                    shreg_d    = bus.wdata;
                    bit_cnt_d  = '0;
                    byte_cnt_d = '0;
                    nack_d     = 1'b0;
                    ack_err_d  = 1'b0;
`ifdef I2C_RETRY_EN
                    wdata_d     = bus.wdata;
                    retry_cnt_d = '0;
`endif
                end
            end
            S_START1: if (tick) state_d = S_START2;
            S_START2: if (tick) state_d = S_BQ0;
            S_BQ0:    if (tick) state_d = S_BQ1;
            S_BQ1:    if (tick) state_d = S_BQ2;
            S_BQ2:    if (tick) state_d = S_BQ3;
            S_BQ3: begin
                if (tick) begin
                    shreg_d = shreg_q << 1;
                    if (bit_cnt_q == 3'd7) begin
                        bit_cnt_d = '0;
                        state_d   = S_AQ0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        state_d   = S_BQ0;
                    end
                end
            end
            S_AQ0: if (tick) state_d = S_AQ1;
            S_AQ1: if (tick) state_d = S_AQ2;
            S_AQ2: begin
                if (tick) begin
                    nack_d  = bus.sda_in;
                    state_d = S_AQ3;
                    if (bus.sda_in && last_attempt) ack_err_d = 1'b1;
                end
            end
            S_AQ3: begin
                if (tick) begin
                    if (nack_q || (byte_cnt_q == len_q - LW'(1))) begin
                        state_d = S_STOP1;
                    end else begin
                        byte_cnt_d = byte_cnt_q + LW'(1);
                        state_d    = S_BQ0;
                    end
                end
            end
            S_STOP1: if (tick) state_d = S_STOP2;
            S_STOP2: if (tick) state_d = S_STOP3;
            S_STOP3: begin
                if (tick) begin
`ifdef I2C_RETRY_EN
                    if (nack_q && !last_attempt) begin
                        retry_cnt_d = retry_cnt_q + RW'(1);
                        bit_cnt_d   = '0;
                        state_d     = S_RWAIT;
                    end else begin
                        state_d = S_DONE;
                    end
`else
                    state_d = S_DONE;
`endif
                end
            end
            S_RWAIT: begin
`ifdef I2C_RETRY_EN
                // Four idle phases, counted with the otherwise unused bit counter.
                if (tick) begin
                    if (bit_cnt_q == 3'd3) begin
                        bit_cnt_d  = '0;
                        byte_cnt_d = '0;
                        shreg_d    = wdata_q;
                        nack_d     = 1'b0;
                        state_d    = S_START1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
`else
                state_d = S_IDLE;
`endif
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // The quarter counter only runs while a transaction is in flight.
        if (state_q == S_IDLE || state_q == S_DONE || tick) begin
            q_cnt_d = '0;
        end else begin
            q_cnt_d = q_cnt_q + QW'(1);
        end

        // Bus levels for the state being entered. A data bit of 1 is sent by
        // releasing SDA, which the open-drain pair reads as sda_ts = bit.
        data_bit  = shreg_d[DW-1];
        scl_d     = 1'b1;
        sda_out_d = 1'b1;
        sda_ts_d  = 1'b1;
        busy_d    = 1'b1;
        done_d    = 1'b0;
        case (state_d)
            S_IDLE:   busy_d = 1'b0;
            S_START1: sda_ts_d = 1'b0;
            S_START2: begin
                sda_ts_d  = 1'b0;
                sda_out_d = 1'b0;
            end
            S_BQ0, S_BQ1: begin
                scl_d     = 1'b0;
                sda_ts_d  = data_bit;
                sda_out_d = data_bit;
            end
            S_BQ2, S_BQ3: begin
                sda_ts_d  = data_bit;
                sda_out_d = data_bit;
            end
            S_AQ0, S_AQ1: scl_d = 1'b0;
            S_STOP1: begin
                scl_d     = 1'b0;
                sda_ts_d  = 1'b0;
                sda_out_d = 1'b0;
            end
            S_STOP2: begin
                sda_ts_d  = 1'b0;
                sda_out_d = 1'b0;
            end
            S_DONE: begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.scl     = scl_q;
    assign bus.sda_out = sda_out_q;
    assign bus.sda_ts  = sda_ts_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.ack_err = ack_err_q;
`ifdef I2C_RETRY_EN
    assign bus.retries = retry_cnt_q;
`endif
endmodule

// File: tb/tb_i2c_write_master.sv
// tb_i2c_write_master
//
// Directed bench for i2c_write_master with CLK_DIV=4, NBYTES=3. A small
// behavioural slave decodes START/STOP, collects the bytes clocked on SCL
// rising edges and ACKs or NACKs each byte as the current test asks. A
// second instance with NBYTES=2 exercises the len > NBYTES guard.
module tb_i2c_write_master;
    localparam int CLK_DIV = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    i2c_write_master_if #(
        .NBYTES(3)
`ifdef I2C_RETRY_EN
        , .MAX_RETRY(3)
`endif
    ) bus ();

    i2c_write_master_if #(
        .NBYTES(2)
`ifdef I2C_RETRY_EN
        , .MAX_RETRY(3)
`endif
    ) bus2 ();

    i2c_write_master #(
        .NBYTES(3),
        .CLK_DIV(CLK_DIV)
`ifdef I2C_RETRY_EN
        , .MAX_RETRY(3)
`endif
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    i2c_write_master #(
        .NBYTES(2),
        .CLK_DIV(CLK_DIV)
`ifdef I2C_RETRY_EN
        , .MAX_RETRY(3)
`endif
    ) dut2 (
        .clk(clk),
        .reset(reset),
        .bus(bus2)
    );

    // Open-drain pad: the slave can only pull low while the master releases.
    logic slave_pull = 1'b0;
    wire  pad = bus.sda_ts ? ~slave_pull : bus.sda_out;
    assign bus.sda_in  = pad;
    assign bus2.sda_in = 1'b1;

    // Slave model state and transaction logs.
    int         nack_byte     = 0;
    int         nack_attempts = 0;
    int         start_count   = 0;
    int         stop_count    = 0;
    int         rx_count      = 0;
    int         done_count    = 0;
    int         rx_bits       = 0;
    int         byte_idx      = 0;
    logic [7:0] rx_byte [0:15];
    logic [7:0] rx_shift = 8'h00;
    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;
    logic       in_ack   = 1'b0;
    logic       scl_now;
    logic       sda_now;

    // Slave: START/STOP by SDA edges with SCL high, data on SCL rising edges,
    // ACK driven from the falling edge after bit 8 to the falling edge after
    // the ACK clock. It NACKs byte nack_byte in the first nack_attempts attempts.
    always @(negedge clk) begin
        scl_now = bus.scl;
        sda_now = pad;
        if (scl_now && prev_scl && prev_sda && !sda_now) begin
            start_count++;
            rx_bits    = 0;
            byte_idx   = 0;
            in_ack     = 1'b0;
            slave_pull = 1'b0;
        end else if (scl_now && prev_scl && !prev_sda && sda_now) begin
            stop_count++;
        end else if (scl_now && !prev_scl) begin
            if (!in_ack && rx_bits < 8) begin
                rx_shift = {rx_shift[6:0], sda_now};
                rx_bits++;
            end
        end else if (!scl_now && prev_scl) begin
            if (in_ack) begin
                in_ack     = 1'b0;
                slave_pull = 1'b0;
                rx_bits    = 0;
            end else if (rx_bits == 8) begin
                in_ack = 1'b1;
                if (rx_count < 16) rx_byte[rx_count] = rx_shift;
                rx_count++;
                byte_idx++;
                slave_pull = !(byte_idx == nack_byte && start_count <= nack_attempts);
            end
        end
        prev_scl = scl_now;
        prev_sda = sda_now;
    end

    always @(negedge clk) begin
        if (bus.done) done_count++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        start_count = 0;
        stop_count  = 0;
        rx_count    = 0;
        done_count  = 0;
    endtask

    // Presents a request for one cycle; returns at the negedge of cycle 1,
    // i.e. half a clock after the accepting edge.
    task automatic applyStimulus(input logic [23:0] data, input logic [1:0] n);
        @(negedge clk);
        bus.start = 1'b1;
        bus.wdata = data;
        bus.len   = n;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Steps cycle by cycle until done is seen; done_at = 0 on timeout.
    task automatic run_to_done(input int first_cyc, input int limit, output int done_at);
        done_at = 0;
        for (int cyc = first_cyc; cyc <= limit; cyc++) begin
            if (bus.done) begin
                done_at = cyc;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int done_at;
        int busy_seen;

        bus.start  = 1'b0;
        bus.wdata  = '0;
        bus.len    = '0;
        bus2.start = 1'b0;
        bus2.wdata = '0;
        bus2.len   = '0;

        repeat (3) @(negedge clk);
        checkOutput("reset_scl", bus.scl, 1);
        checkOutput("reset_sda_out", bus.sda_out, 1);
        checkOutput("reset_sda_ts", bus.sda_ts, 1);
        checkOutput("reset_busy", bus.busy, 0);
        checkOutput("reset_done", bus.done, 0);
        checkOutput("reset_ack_err", bus.ack_err, 0);
        reset = 1'b0;

        $display("[TB] basic write, len=3");
        clear_logs();
        nack_byte = 0;
        applyStimulus(24'h341E00, 2'd3);
        checkOutput("basic_busy_c1", bus.busy, 1);
        run_to_done(1, 700, done_at);
        checkOutput("basic_done_cycle", done_at, 453);
        checkOutput("basic_busy_at_done", bus.busy, 0);
        checkOutput("basic_ack_err", bus.ack_err, 0);
        checkOutput("basic_rx_count", rx_count, 3);
        checkOutput("basic_byte0", rx_byte[0], 8'h34);
        checkOutput("basic_byte1", rx_byte[1], 8'h1E);
        checkOutput("basic_byte2", rx_byte[2], 8'h00);
        checkOutput("basic_starts", start_count, 1);
        checkOutput("basic_stops", stop_count, 1);
        @(negedge clk);
        checkOutput("basic_done_one_cycle", bus.done, 0);
        checkOutput("basic_done_count", done_count, 1);

        $display("[TB] address NACK");
        repeat (5) @(negedge clk);
        clear_logs();
        nack_byte     = 1;
        nack_attempts = 100;
        applyStimulus(24'h341E00, 2'd3);
`ifdef I2C_RETRY_EN
        run_to_done(1, 1200, done_at);
        checkOutput("nack_done_cycle", done_at, 705);
        checkOutput("nack_ack_err", bus.ack_err, 1);
        checkOutput("nack_retries", bus.retries, 3);
        checkOutput("nack_starts", start_count, 4);
        checkOutput("nack_stops", stop_count, 4);
        checkOutput("nack_rx_count", rx_count, 4);
`else
        run_to_done(1, 700, done_at);
        checkOutput("nack_done_cycle", done_at, 165);
        checkOutput("nack_ack_err", bus.ack_err, 1);
        checkOutput("nack_starts", start_count, 1);
        checkOutput("nack_stops", stop_count, 1);
        checkOutput("nack_rx_count", rx_count, 1);
`endif
        @(negedge clk);
        checkOutput("nack_done_count", done_count, 1);
        checkOutput("nack_ack_err_held", bus.ack_err, 1);
        nack_byte = 0;

        $display("[TB] single byte, len=1");
        repeat (5) @(negedge clk);
        clear_logs();
        applyStimulus(24'h35AABB, 2'd1);
        checkOutput("len1_ack_err_cleared", bus.ack_err, 0);
`ifdef I2C_RETRY_EN
        checkOutput("len1_retries_cleared", bus.retries, 0);
`endif
        run_to_done(1, 700, done_at);
        checkOutput("len1_done_cycle", done_at, 165);
        checkOutput("len1_rx_count", rx_count, 1);
        checkOutput("len1_byte0", rx_byte[0], 8'h35);
        checkOutput("len1_ack_err", bus.ack_err, 0);

        $display("[TB] illegal lengths");
        repeat (5) @(negedge clk);
        clear_logs();
        applyStimulus(24'h123456, 2'd0);
        busy_seen = 0;
        for (int i = 0; i < 60; i++) begin
            if (bus.busy) busy_seen++;
            @(negedge clk);
        end
        checkOutput("len0_busy", busy_seen, 0);
        checkOutput("len0_done", done_count, 0);
        checkOutput("len0_starts", start_count, 0);

        bus2.start = 1'b1;
        bus2.wdata = 16'hA1B2;
        bus2.len   = 2'd3;
        @(negedge clk);
        bus2.start = 1'b0;
        busy_seen  = 0;
        for (int i = 0; i < 60; i++) begin
            if (bus2.busy || bus2.done) busy_seen++;
            @(negedge clk);
        end
        checkOutput("len_over_busy", busy_seen, 0);
        bus2.start = 1'b1;
        bus2.len   = 2'd2;
        @(negedge clk);
        bus2.start = 1'b0;
        checkOutput("len_max_busy", bus2.busy, 1);

        $display("[TB] busy guard");
        repeat (5) @(negedge clk);
        clear_logs();
        applyStimulus(24'h123456, 2'd3);
        repeat (9) @(negedge clk);
        bus.start = 1'b1;
        bus.wdata = 24'hFFFFFF;
        bus.len   = 2'd1;
        @(negedge clk);
        bus.start = 1'b0;
        run_to_done(11, 700, done_at);
        checkOutput("guard_done_cycle", done_at, 453);
        checkOutput("guard_byte0", rx_byte[0], 8'h12);
        checkOutput("guard_byte1", rx_byte[1], 8'h34);
        checkOutput("guard_byte2", rx_byte[2], 8'h56);
        repeat (100) @(negedge clk);
        checkOutput("guard_done_count", done_count, 1);
        checkOutput("guard_busy_after", bus.busy, 0);
        checkOutput("guard_starts", start_count, 1);

        $display("[TB] reset during byte 2");
        clear_logs();
        applyStimulus(24'hA55A3C, 2'd3);
        repeat (179) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midrst_scl", bus.scl, 1);
        checkOutput("midrst_sda_ts", bus.sda_ts, 1);
        checkOutput("midrst_sda_out", bus.sda_out, 1);
        checkOutput("midrst_busy", bus.busy, 0);
        checkOutput("midrst_done", bus.done, 0);
        reset = 1'b0;
        repeat (100) @(negedge clk);
        checkOutput("midrst_no_done", done_count, 0);
        checkOutput("midrst_stays_idle", bus.busy, 0);
        clear_logs();
        applyStimulus(24'hA55A3C, 2'd3);
        run_to_done(1, 700, done_at);
        checkOutput("postrst_done_cycle", done_at, 453);
        checkOutput("postrst_byte0", rx_byte[0], 8'hA5);
        checkOutput("postrst_byte1", rx_byte[1], 8'h5A);
        checkOutput("postrst_byte2", rx_byte[2], 8'h3C);
        checkOutput("postrst_ack_err", bus.ack_err, 0);

`ifdef I2C_RETRY_EN
        $display("[TB] retry recovery");
        repeat (5) @(negedge clk);
        clear_logs();
        nack_byte     = 1;
        nack_attempts = 1;
        applyStimulus(24'h341E00, 2'd3);
        run_to_done(1, 1200, done_at);
        checkOutput("retry_done_cycle", done_at, 633);
        checkOutput("retry_ack_err", bus.ack_err, 0);
        checkOutput("retry_retries", bus.retries, 1);
        checkOutput("retry_rx_count", rx_count, 4);
        checkOutput("retry_last_byte", rx_byte[3], 8'h00);
        repeat (20) @(negedge clk);
        checkOutput("retry_done_count", done_count, 1);
        nack_byte = 0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule

// File: doc/i2c_write_master.md
Name: i2c_write_master

Overview:
- Parametrised I2C write master that replaces the hand-driven SCLK/SDAT path used for audio-codec bring-up.
- Performs one START / N-byte write / STOP transaction per request and checks each slave ACK.
- Drives SCL push-pull and SDA as an open-drain pair (`sda_out` plus tri-state enable). Top level resolves the pad as `FPGA_I2C_SDAT = sda_ts ? Z : sda_out`.
- Sits between a configuration sequencer (or ISSP) and the codec I2C pins.

Parameters:
- NBYTES, 3, maximum bytes per transaction including the address byte (WM8731 needs 3: addr, reg/data-hi, data-lo).
- CLK_DIV, 125, clk cycles per quarter SCL period (50 MHz gives 100 kHz SCL); legal range ≥2.
- MAX_RETRY, 3, retries after NACK; used only when I2C_RETRY_EN is defined.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when idle.
- wdata  in  8*NBYTES  bytes to send; first byte = wdata[8*NBYTES-1 -: 8], MSB first.
- len  in  $clog2(NBYTES+1)  number of bytes to send, 1..NBYTES.
- sda_in  in  1  synchronised SDA pad value.
- scl  out  1  SCL drive.
- sda_out  out  1  SDA drive value.
- sda_ts  out  1  1 = release SDA (high-Z).
- busy  out  1  transaction in progress.
- done  out  1  one-cycle completion pulse.
- ack_err  out  1  NACK seen in the last transaction.

Behaviour:
- Reset values: scl=1, sda_out=1, sda_ts=1, busy=0, done=0, ack_err=0. The quarter counter, byte counter and bit counter clear to 0.
- Reset mid-transaction: the bus is released on the next cycle with no STOP generated and no done pulse.
- Quarter tick: a counter 0..CLK_DIV-1 runs only while busy. Every phase below lasts exactly one tick period (CLK_DIV cycles).
- Data inputs: wdata and len are latched when start is accepted; later changes are ignored.
- Start acceptance: start=1 while busy=0, with 1≤len≤NBYTES, is accepted at that edge.
  - busy=1 from the next cycle.
  - ack_err clears on acceptance.
  - len=0 or len>NBYTES: request is ignored (no busy, no done).
  - start while busy=1: ignored.
- FSM states and bus levels:
  - IDLE: scl=1, SDA released.
  - START: 2 phases. Phase 1: SDA driven 1, scl=1. Phase 2: SDA driven 0, scl=1.
  - BIT: 4 phases per bit, 8 bits MSB first.
    - Q0: scl=0, drive the data bit (0 → sda_ts=0, sda_out=0; 1 → release).
    - Q1: scl=0.
    - Q2: scl=1.
    - Q3: scl=1.
  - ACK: same 4 phases with SDA released. sda_in is sampled on the last cycle of Q2; 0 = ACK.
  - STOP: 3 phases.
    - scl=0, SDA driven 0.
    - scl=1, SDA driven 0.
    - scl=1, SDA released.
  - DONE: one cycle; done=1, busy=0; returns to IDLE.
- Transitions:
  - ACK with more bytes pending → BIT (next byte).
  - ACK after the last byte → STOP.
  - NACK → ack_err=1, remaining bytes abandoned, go to STOP.
- Latency:
  - Full success: done asserts exactly 1 + CLK_DIV*(5+36*len) cycles after the accepting edge.
  - NACK on byte k (1-based): done asserts exactly 1 + CLK_DIV*(5+36*k) cycles after the accepting edge.
- ack_err is held until the next accepted start or reset.
- sda_in value outside the ACK sample point is ignored. No arbitration or clock stretching is supported.

Optional Feature:
- Macro I2C_RETRY_EN.
- Defined:
  - On NACK, after STOP completes, the bus idles for 4 phases (scl=1, SDA released), then the whole transaction restarts from byte 0.
  - Up to MAX_RETRY restarts are made.
  - busy stays 1 and done is not pulsed between attempts.
  - ack_err=1 only if the final attempt NACKs.
  - Extra output `retries` [$clog2(MAX_RETRY+1)-1:0] holds the number of restarts used; it clears on acceptance.
- Undefined: the first NACK ends the transaction as described in Behaviour; the `retries` port is absent.

Test Plan:
- Basic write: CLK_DIV=4, len=3, wdata=0x34_1E_00, slave ACKs all bytes.
  - Required: START, then bits 00110100 / 00011110 / 00000000 on SCL rising edges.
  - done at cycle 1+4*113=453; ack_err=0.
- Address NACK: slave releases on the first ACK.
  - Required: STOP immediately after byte 1; done at 1+4*41=165; ack_err=1.
  - With I2C_RETRY_EN and MAX_RETRY=3: 4 attempts, retries=3, ack_err=1.
- Short and illegal lengths:
  - len=1, wdata top byte 0x35 → single byte then STOP; done at 1+4*41.
  - len=0 and len=4 → busy stays 0, no done.
- Busy guard: pulse start again 10 cycles into a transaction with different wdata → first transaction completes unchanged, and exactly one done pulse occurs.
- Reset mid-byte: assert reset during byte 2 → next cycle scl=1, sda_ts=1, busy=0, no done. A following start is accepted and completes normally.
- Retry recovery (I2C_RETRY_EN): slave NACKs the first attempt and ACKs the second → done once, ack_err=0, retries=1.
